pll_lock_reset_gen: RTL and testbench
=====================================

PLL_LOCK_RESET_GEN -- requirements
Module: pll_lock_reset_gen

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset; the clock port is named GL0 and the reset port is named RESET.
REQ-002 Parameter STABLE_CYCLES, default 1024, is the number of consecutive synchronized-LOCK-high cycles required before reset release.
REQ-003 Parameter MIN_HOLD_CYCLES, default 16, is the minimum FABRIC_RESET_N low time after a lock loss.
REQ-004 Parameter GLITCH_CYCLES, default 4, is the number of consecutive low samples that declare a loss (filter build only).
REQ-005 Parameter CNT_W, default 8, is the width of LOSS_COUNT.
REQ-006 GL0  in  1  fabric clock from the FCCC GL0 output.
REQ-007 RESET  in  1  asynchronous active-high reset.
REQ-008 LOCK  in  1  FCCC PLL lock indicator, asynchronous to GL0.
REQ-009 CLR_STATUS  in  1  synchronous clear of LOCK_LOST and LOSS_COUNT.
REQ-010 FABRIC_RESET_N  out  1  registered, active-low fabric reset.
REQ-011 LOCK_LOST  out  1  sticky flag, set when a lock loss occurs in RUN.
REQ-012 LOSS_COUNT  out  CNT_W  saturating count of lock losses in RUN.
REQ-013 STATE  out  2  current FSM state, for debug.

Function
REQ-014 SHALL synchronize LOCK through 2 flops to form lock_s; lock_s first reflects a LOCK edge after the 2nd GL0 edge.
REQ-015 FSM states and encoding: WAIT=0, STABLE=1, RUN=2, HOLD=3.
REQ-016 WAIT: when lock_s=1, SHALL go to STABLE and clear the counter.
REQ-017 STABLE: when lock_s=0, SHALL return to WAIT; LOCK_LOST and LOSS_COUNT SHALL NOT change.
REQ-018 STABLE: when lock_s=1 and the counter equals STABLE_CYCLES-1, SHALL go to RUN; otherwise the counter increments.
REQ-019 FABRIC_RESET_N SHALL be a flop loaded from (next_state==RUN); it rises on the (STABLE_CYCLES+3)th GL0 edge after LOCK rises.
REQ-020 RUN: on a loss decision, SHALL go to HOLD, set LOCK_LOST, and increment LOSS_COUNT, saturating at all-ones.
REQ-021 HOLD: SHALL stay for exactly MIN_HOLD_CYCLES cycles, ignoring lock_s, then go to WAIT.
REQ-022 CLR_STATUS SHALL clear LOCK_LOST and LOSS_COUNT on the next edge.
REQ-023 When CLR_STATUS coincides with a loss decision, LOCK_LOST SHALL be 1 and LOSS_COUNT SHALL be 1.
REQ-024 The internal counter width SHALL be clog2 of the maximum of STABLE_CYCLES, MIN_HOLD_CYCLES and GLITCH_CYCLES, and at least 1.
REQ-025 Each of STABLE_CYCLES, MIN_HOLD_CYCLES and GLITCH_CYCLES SHALL be at least 1; an elaboration-time check SHALL enforce this.

Reset
REQ-026 RESET high SHALL asynchronously force: state=WAIT, all counters=0, sync flops=0, FABRIC_RESET_N=0, LOCK_LOST=0, LOSS_COUNT=0, STATE=0.
REQ-027 RESET asserted in any state, including mid-RUN or mid-HOLD, SHALL drop FABRIC_RESET_N immediately, without waiting for a GL0 edge.
REQ-028 After RESET is released, the sequence SHALL restart from WAIT; RESET deassertion is synchronous to GL0, supplied upstream.

Configuration
REQ-029 Macro PLL_LOCK_GLITCH_FILTER_EN defined: a loss is declared only after GLITCH_CYCLES consecutive lock_s=0 samples in RUN; any lock_s=1 sample clears the filter count.
REQ-030 With the filter, FABRIC_RESET_N falls on GL0 edge 2+GLITCH_CYCLES after LOCK falls.
REQ-031 Macro PLL_LOCK_GLITCH_FILTER_EN undefined: the first lock_s=0 sample in RUN is a loss; FABRIC_RESET_N falls on edge 3; no filter logic is generated.

Structure
REQ-032 Package pll_lock_reset_pkg SHALL hold the state typedef, the state encodings, and the default parameter constants.
REQ-033 The synchronizer SHALL be a sub-module named lock_sync, with 2 flops and async reset to 0.

Verification
REQ-034 Power-up: STABLE_CYCLES=8, RESET high 3 cycles then low, LOCK rises -> FABRIC_RESET_N=1 and STATE=2 after the 11th edge.
REQ-035 Bounce in STABLE: LOCK low for 1 cycle mid-count -> STATE returns to 0 and the count restarts; LOCK_LOST stays 0 and LOSS_COUNT stays 0.
REQ-036 Loss in RUN, filter off, MIN_HOLD=4: LOCK falls -> FABRIC_RESET_N=0 at edge 3, LOCK_LOST=1, LOSS_COUNT=1; HOLD lasts 4 cycles, then WAIT even with LOCK already high.
REQ-037 Filter on, GLITCH_CYCLES=4: a 3-cycle LOCK low -> no reset; a 4-cycle LOCK low -> FABRIC_RESET_N=0 at edge 6.
REQ-038 CNT_W=2, 5 losses -> LOSS_COUNT=3; CLR_STATUS coincident with a 6th loss -> LOCK_LOST=1, LOSS_COUNT=1.
REQ-039 RESET pulsed mid-RUN -> FABRIC_RESET_N=0 before the next GL0 edge; status outputs=0; after RESET is released, the full STABLE_CYCLES sequence repeats.

Source files
------------

// File: rtl/pll_lock_reset_pkg.sv
// pll_lock_reset_pkg: FSM state type and default cycle counts for the PLL lock reset generator.
package pll_lock_reset_pkg;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_STABLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DEF_STABLE_CYCLES   = 1024;
   localparam int DEF_MIN_HOLD_CYCLES = 16;
   localparam int DEF_GLITCH_CYCLES   = 4;
   localparam int DEF_CNT_W           = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_sync.sv
// lock_sync: two-flop synchronizer for the asynchronous PLL lock indicator.
module lock_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_reset_gen.sv
// pll_lock_reset_gen: holds fabric reset until PLL lock is stable, re-asserts it on lock loss.
// Define PLL_LOCK_GLITCH_FILTER_EN to require GLITCH_CYCLES consecutive low samples before a loss.
module pll_lock_reset_gen
   import pll_lock_reset_pkg::*;
#(
   parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
   parameter int MIN_HOLD_CYCLES = DEF_MIN_HOLD_CYCLES,
   parameter int GLITCH_CYCLES   = DEF_GLITCH_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic             GL0,
   input  logic             RESET,
   input  logic             LOCK,
   input  logic             CLR_STATUS,
   output logic             FABRIC_RESET_N,
   output logic             LOCK_LOST,
   output logic [CNT_W-1:0] LOSS_COUNT,
   output logic [1:0]       STATE
);

   localparam int MAXC = max3(STABLE_CYCLES, MIN_HOLD_CYCLES, GLITCH_CYCLES);
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(MIN_HOLD_CYCLES - 1);

   if (STABLE_CYCLES < 1 || MIN_HOLD_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_bad_param
      $error("pll_lock_reset_gen: STABLE_CYCLES, MIN_HOLD_CYCLES and GLITCH_CYCLES must be >= 1");
   end

   logic             w_lock_s;
   logic             w_loss;
   state_t           w_next;
   logic [CW-1:0]    w_cnt_nxt;
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_rst_n;
   logic             r_lost;
   logic [CNT_W-1:0] r_loss_cnt;

   lock_sync u_lock_sync (
      .i_clk (GL0),
      .i_rst (RESET),
      .i_d   (LOCK),
      .o_q   (w_lock_s)
   );

   // In RUN the shared counter tracks consecutive low samples of the synchronized lock.
`ifdef PLL_LOCK_GLITCH_FILTER_EN
   localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);
   assign w_loss = (r_state == ST_RUN) && !w_lock_s && (r_cnt == GLITCH_LAST);
`else
   assign w_loss = (r_state == ST_RUN) && !w_lock_s;
`endif

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         ST_WAIT:
            if (w_lock_s) begin
               w_next    = ST_STABLE;
               w_cnt_nxt = '0;
            end
         ST_STABLE:
            if (!w_lock_s) begin
               w_next    = ST_WAIT;
               w_cnt_nxt = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_next    = ST_RUN;
               w_cnt_nxt = '0;
            end else
               w_cnt_nxt = r_cnt + 1'b1;
         ST_RUN:
            if (w_loss) begin
               w_next    = ST_HOLD;
               w_cnt_nxt = '0;
            end
`ifdef PLL_LOCK_GLITCH_FILTER_EN
            else
               w_cnt_nxt = w_lock_s ? '0 : r_cnt + 1'b1;
`endif
         ST_HOLD:
            if (r_cnt == HOLD_LAST) begin
               w_next    = ST_WAIT;
               w_cnt_nxt = '0;
            end else
               w_cnt_nxt = r_cnt + 1'b1;
      endcase
   end

   // A loss coincident with a clear wins: the new event is reported as the first.
   always_ff @(posedge GL0 or posedge RESET)
      if (RESET) begin
         r_state    <= ST_WAIT;
         r_cnt      <= '0;
         r_rst_n    <= 1'b0;
         r_lost     <= 1'b0;
         r_loss_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_cnt      <= w_cnt_nxt;
         r_rst_n    <= (w_next == ST_RUN);
         r_lost     <= w_loss | (r_lost & ~CLR_STATUS);
         r_loss_cnt <= CLR_STATUS ? CNT_W'(w_loss) : r_loss_cnt + CNT_W'(w_loss && !(&r_loss_cnt));
      end

   assign FABRIC_RESET_N = r_rst_n;
   assign LOCK_LOST      = r_lost;
   assign LOSS_COUNT     = r_loss_cnt;
   assign STATE          = r_state;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// tb_pll_lock_reset_gen: directed stimulus checked every cycle against an elapsed-time model plus literal edge checks.
module tb_pll_lock_reset_gen;

   localparam int S    = 8;
   localparam int H    = 4;
   localparam int G    = 4;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
   localparam int GL = G;
`else
   localparam int GL = 1;
`endif
   localparam int E = 2 + GL;

   logic          GL0 = 1'b0;
   logic          RESET = 1'b1;
   logic          LOCK = 1'b0;
   logic          CLR_STATUS = 1'b0;
   logic          FABRIC_RESET_N;
   logic          LOCK_LOST;
   logic [CW-1:0] LOSS_COUNT;
   logic [1:0]    STATE;

   int checks = 0;
   int errors = 0;

   pll_lock_reset_gen #(
      .STABLE_CYCLES   (S),
      .MIN_HOLD_CYCLES (H),
      .GLITCH_CYCLES   (G),
      .CNT_W           (CW)
   ) dut (
      .GL0            (GL0),
      .RESET          (RESET),
      .LOCK           (LOCK),
      .CLR_STATUS     (CLR_STATUS),
      .FABRIC_RESET_N (FABRIC_RESET_N),
      .LOCK_LOST      (LOCK_LOST),
      .LOSS_COUNT     (LOSS_COUNT),
      .STATE          (STATE)
   );

   always #5 GL0 = ~GL0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: lock_s is LOCK as sampled two edges earlier; phases end by elapsed edge counts.
   bit q[$];
   int n, t_in, zeros, m_state, m_cnt;
   bit m_rstn, m_lost, ls, loss;

   always @(posedge GL0 or posedge RESET) begin
      if (RESET) begin
         q.delete();
         n = 0; t_in = 0; zeros = 0; m_state = 0; m_cnt = 0;
         m_rstn = 0; m_lost = 0;
      end else begin
         n++;
         ls = (q.size() >= 2) ? q[q.size()-2] : 1'b0;
         q.push_back(LOCK);
         if (q.size() > 4) void'(q.pop_front());
         loss = 0;
         case (m_state)
            0: if (ls) begin m_state = 1; t_in = n; end
            1: if (!ls) m_state = 0;
               else if (n - t_in == S) begin m_state = 2; zeros = 0; end
            2: begin
                  zeros = ls ? 0 : zeros + 1;
                  if (zeros == GL) begin loss = 1; m_state = 3; t_in = n; end
               end
            default: if (n - t_in == H) m_state = 0;
         endcase
         m_rstn = (m_state == 2);
         if (CLR_STATUS) begin
            m_lost = loss;
            m_cnt  = loss ? 1 : 0;
         end else if (loss) begin
            m_lost = 1;
            m_cnt  = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
         end
      end
   end

   always @(negedge GL0) begin
      chk("state", STATE, m_state);
      chk("fabric_reset_n", FABRIC_RESET_N, m_rstn);
      chk("lock_lost", LOCK_LOST, m_lost);
      chk("loss_count", LOSS_COUNT, m_cnt);
   end

   task automatic do_loss();
      @(negedge GL0);
      LOCK = 1'b0;
      repeat (E) @(negedge GL0);
      LOCK = 1'b1;
      repeat (20) @(negedge GL0);
   endtask

   initial begin
      repeat (3) @(negedge GL0);
      chk("reset_rst_n", FABRIC_RESET_N, 0);
      chk("reset_state", STATE, 0);
      chk("reset_lost", LOCK_LOST, 0);
      chk("reset_count", LOSS_COUNT, 0);
      RESET = 1'b0;
      repeat (2) @(negedge GL0);

      // one-cycle bounce while counting in STABLE
      LOCK = 1'b1;
      repeat (6) @(negedge GL0);
      chk("bounce_pre_state", STATE, 1);
      LOCK = 1'b0;
      @(negedge GL0);
      LOCK = 1'b1;
      repeat (2) @(posedge GL0);
      #1 chk("bounce_wait_state", STATE, 0);
      chk("bounce_lost", LOCK_LOST, 0);
      chk("bounce_count", LOSS_COUNT, 0);
      repeat (8) @(posedge GL0);
      #1 chk("edge10_state", STATE, 1);
      chk("edge10_rst_n", FABRIC_RESET_N, 0);
      @(posedge GL0);
      #1 chk("edge11_state", STATE, 2);
      chk("edge11_rst_n", FABRIC_RESET_N, 1);
      @(negedge GL0);

`ifdef PLL_LOCK_GLITCH_FILTER_EN
      LOCK = 1'b0;
      repeat (3) @(negedge GL0);
      LOCK = 1'b1;
      repeat (8) @(negedge GL0);
      chk("glitch3_state", STATE, 2);
      chk("glitch3_rst_n", FABRIC_RESET_N, 1);
      chk("glitch3_count", LOSS_COUNT, 0);
`endif

      // loss in RUN; HOLD must run its full length though LOCK returns at once
      LOCK = 1'b0;
      repeat (E - 1) @(posedge GL0);
      #1 chk("loss_pre_rst_n", FABRIC_RESET_N, 1);
      @(posedge GL0);
      #1 chk("loss_rst_n", FABRIC_RESET_N, 0);
      chk("loss_state", STATE, 3);
      chk("loss_lost", LOCK_LOST, 1);
      chk("loss_count", LOSS_COUNT, 1);
      LOCK = 1'b1;
      repeat (3) @(posedge GL0);
      #1 chk("hold_last_state", STATE, 3);
      @(posedge GL0);
      #1 chk("hold_exit_state", STATE, 0);
      @(posedge GL0);
      #1 chk("restable_state", STATE, 1);
      repeat (10) @(negedge GL0);
      chk("rerun_state", STATE, 2);

      CLR_STATUS = 1'b1;
      @(negedge GL0);
      CLR_STATUS = 1'b0;
      chk("clr_lost", LOCK_LOST, 0);
      chk("clr_count", LOSS_COUNT, 0);

      repeat (5) do_loss();
      chk("sat_count", LOSS_COUNT, 3);
      chk("sat_lost", LOCK_LOST, 1);

      // clear coincident with a sixth loss
      @(negedge GL0);
      LOCK = 1'b0;
      repeat (E - 1) @(negedge GL0);
      CLR_STATUS = 1'b1;
      @(posedge GL0);
      #1 chk("clr_loss_lost", LOCK_LOST, 1);
      chk("clr_loss_count", LOSS_COUNT, 1);
      @(negedge GL0);
      CLR_STATUS = 1'b0;
      LOCK = 1'b1;
      repeat (20) @(negedge GL0);
      chk("pre_reset_state", STATE, 2);

      // asynchronous reset in the middle of a cycle
      @(posedge GL0);
      #2 RESET = 1'b1;
      #1 chk("async_rst_n", FABRIC_RESET_N, 0);
      chk("async_state", STATE, 0);
      chk("async_lost", LOCK_LOST, 0);
      chk("async_count", LOSS_COUNT, 0);
      repeat (2) @(negedge GL0);
      RESET = 1'b0;
      repeat (10) @(posedge GL0);
      #1 chk("rel_edge10_state", STATE, 1);
      chk("rel_edge10_rst_n", FABRIC_RESET_N, 0);
      @(posedge GL0);
      #1 chk("rel_edge11_state", STATE, 2);
      chk("rel_edge11_rst_n", FABRIC_RESET_N, 1);
      repeat (3) @(negedge GL0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
